pry2oht_arb: RTL and testbench

PRY2OHT_ARB -- requirements
Module: pry2oht_arb

---
 rtl/pry2oht_arb.sv | 187 ++++++++++++++++++
 tb/tb_pry2oht_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pry2oht_arb.sv
// pry2oht_arb: round-robin arbiter with a registered one-hot grant and a
// valid/ready handshake on the grant side.
//
// Ports:
//   clk      in   1         clock, all state updates on the rising edge
//   rst      in   1         synchronous active-high reset
//   req      in   WIDTH     request vector, any number of bits set
//   gnt      out  WIDTH     registered one-hot grant, zero when gnt_vld=0
//   gnt_idx  out  WIDTH_LOG binary index of the gnt bit, zero when gnt_vld=0
//   gnt_vld  out  1         a grant is being presented
//   gnt_rdy  in   1         consumer accepts the grant (transfer = vld & rdy)
//
// DIRECTION selects the scan order: "LSB" scans upward from bit 0,
// "MSB" scans downward from bit WIDTH-1.

// pry2oht_tree: priority-to-one-hot stage. Keeps only the first set bit of
// pri in scan direction. Each output bit is gated by a "seen" prefix, so
// once the winning bit has been passed, later input bits (even X) are
// ANDed with zero and cannot disturb the result.
module pry2oht_tree #(
  parameter int WIDTH     = 16,
  parameter     DIRECTION = "LSB"
) (
  input  logic [WIDTH-1:0] pri,
  output logic [WIDTH-1:0] oht
);

  localparam bit SCAN_MSB = (DIRECTION == "MSB");

  // Walk the vector in scan order, passing only the first set bit.
  always_comb begin
    logic seen;
    seen = 1'b0;
    oht  = '0;
    if (SCAN_MSB) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        oht[i] = pri[i] & ~seen;
        seen   = seen | pri[i];
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        oht[i] = pri[i] & ~seen;
        seen   = seen | pri[i];
      end
    end
  end

endmodule

module pry2oht_arb #(
  parameter int WIDTH     = 16,
  parameter     DIRECTION = "LSB",
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  output logic [WIDTH-1:0]     gnt,
  output logic [WIDTH_LOG-1:0] gnt_idx,
  output logic                 gnt_vld,
  input  logic                 gnt_rdy
);

  localparam bit SCAN_MSB = (DIRECTION == "MSB");

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     msk_q, msk_d;
  logic [WIDTH-1:0]     gnt_d;
  logic [WIDTH_LOG-1:0] gnt_idx_d;

  logic                 xfer;
  logic [WIDTH-1:0]     msk_after;
  logic [WIDTH-1:0]     arb_msk;
  logic [WIDTH-1:0]     masked_req;
  logic [WIDTH-1:0]     oht_masked;
  logic [WIDTH-1:0]     oht_full;
  logic [WIDTH-1:0]     pick;
  logic [WIDTH_LOG-1:0] pick_idx;

  assign gnt_vld = (state_q == GRANT);
  assign xfer    = gnt_vld & gnt_rdy;

  // Mask left behind by the current grant: every bit strictly past the
  // granted bit in scan direction. Empty when the last bit was granted,
  // which makes the next arbitration wrap to the start.
  always_comb begin
    logic acc;
    acc       = 1'b0;
    msk_after = '0;
    if (SCAN_MSB) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        msk_after[i] = acc;
        acc          = acc | gnt[i];
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        msk_after[i] = acc;
        acc          = acc | gnt[i];
      end
    end
  end

  // On a transfer the new mask must already apply to this cycle's
  // arbitration so back-to-back grants honour round-robin order.
  assign arb_msk    = xfer ? msk_after : msk_q;
  assign masked_req = req & arb_msk;

  pry2oht_tree #(.WIDTH(WIDTH), .DIRECTION(DIRECTION)) u_tree_masked (
    .pri (masked_req),
    .oht (oht_masked)
  );

  pry2oht_tree #(.WIDTH(WIDTH), .DIRECTION(DIRECTION)) u_tree_full (
    .pri (req),
    .oht (oht_full)
  );

  assign pick = (|masked_req) ? oht_masked : oht_full;

  // One-hot to binary encode of the arbitration winner.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pick[i]) begin
        pick_idx = pick_idx | WIDTH_LOG'(i);
      end
    end
  end

  // Next-state and next-grant logic. Outside of an accepted transfer the
  // presented grant is frozen regardless of what req does.
  always_comb begin
    state_d   = state_q;
    msk_d     = msk_q;
    gnt_d     = gnt;
    gnt_idx_d = gnt_idx;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d   = GRANT;
          gnt_d     = pick;
          gnt_idx_d = pick_idx;
        end
      end
      GRANT: begin
        if (gnt_rdy) begin
          msk_d = msk_after;
          if (|req) begin
            gnt_d     = pick;
            gnt_idx_d = pick_idx;
          end else begin
            state_d   = IDLE;
            gnt_d     = '0;
            gnt_idx_d = '0;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = '0;
        gnt_idx_d = '0;
      end
    endcase
  end

  // State, grant and mask registers. Reset wins over any transfer and
  // restores plain scan-order priority with an all-ones mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      msk_q   <= '1;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      gnt_idx <= gnt_idx_d;
      msk_q   <= msk_d;
    end
  end

endmodule

// File: tb/tb_pry2oht_arb.sv
// tb_pry2oht_arb: scoreboard bench for pry2oht_arb with WIDTH=4.
// Two instances share the stimulus: one scanning "LSB", one "MSB".
// A reference model issues expected grants into per-instance queues;
// a monitor compares the presented grant against the queue head.
module tb_pry2oht_arb;

  localparam int W  = 4;
  localparam int WL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          gnt_rdy;
  logic [W-1:0]  req;

  logic [W-1:0]  gnt_l, gnt_m;
  logic [WL-1:0] idx_l, idx_m;
  logic          vld_l, vld_m;

  int checks = 0;
  int errors = 0;

  int exp_q_l[$];
  int exp_q_m[$];

  bit m_vld[2];
  int m_idx[2];
  int m_ptr[2];

  always #5 clk = ~clk;

  pry2oht_arb #(.WIDTH(W), .DIRECTION("LSB")) dut_lsb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt_l),
    .gnt_idx (idx_l),
    .gnt_vld (vld_l),
    .gnt_rdy (gnt_rdy)
  );

  pry2oht_arb #(.WIDTH(W), .DIRECTION("MSB")) dut_msb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt_m),
    .gnt_idx (idx_m),
    .gnt_vld (vld_m),
    .gnt_rdy (gnt_rdy)
  );

  // Round-robin pick: search from ptr onward in scan direction, then
  // wrap and search the whole vector.
  function automatic int pick(input logic [W-1:0] r, input int ptr, input bit msb);
    if (!msb) begin
      for (int i = ptr; i < W; i++) if (r[i]) return i;
      for (int i = 0; i < W; i++) if (r[i]) return i;
    end else begin
      for (int i = ptr; i >= 0; i--) if (r[i]) return i;
      for (int i = W - 1; i >= 0; i--) if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input int d, input int e);
    if (d == 0) exp_q_l.push_back(e);
    else        exp_q_m.push_back(e);
  endtask

  // Reference model: advances once per rising edge using the inputs
  // sampled there and issues each new grant into its queue.
  initial begin
    for (int d = 0; d < 2; d++) begin
      m_vld[d] = 1'b0;
      m_idx[d] = 0;
      m_ptr[d] = (d == 1) ? W - 1 : 0;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          m_vld[d] = 1'b0;
          m_ptr[d] = (d == 1) ? W - 1 : 0;
          if (d == 0) exp_q_l.delete();
          else        exp_q_m.delete();
        end else if (!m_vld[d]) begin
          if (req != '0) begin
            m_idx[d] = pick(req, m_ptr[d], d == 1);
            m_vld[d] = 1'b1;
            pushExp(d, m_idx[d]);
          end
        end else if (gnt_rdy) begin
          m_ptr[d] = (d == 1) ? m_idx[d] - 1 : m_idx[d] + 1;
          if (req != '0) begin
            m_idx[d] = pick(req, m_ptr[d], d == 1);
            pushExp(d, m_idx[d]);
          end else begin
            m_vld[d] = 1'b0;
          end
        end
      end
    end
  end

  task automatic checkDut(input int d, input logic v, input logic [W-1:0] g, input logic [WL-1:0] ix);
    int e;
    string tag;
    tag = (d == 0) ? "lsb" : "msb";
    checkOutput({tag, "_vld"}, 32'(v), 32'(m_vld[d]));
    if (v !== 1'b1) begin
      checkOutput({tag, "_idle_gnt"}, 32'(g), 32'd0);
      checkOutput({tag, "_idle_idx"}, 32'(ix), 32'd0);
    end else begin
      if ((d == 0 && exp_q_l.size() == 0) || (d == 1 && exp_q_m.size() == 0)) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s_unexpected_grant: got gnt %0h, no grant expected", tag, g);
      end else begin
        e = (d == 0) ? exp_q_l[0] : exp_q_m[0];
        checkOutput({tag, "_gnt"}, 32'(g), 32'd1 << e);
        checkOutput({tag, "_idx"}, 32'(ix), 32'(e));
        if (gnt_rdy && !rst) begin
          if (d == 0) void'(exp_q_l.pop_front());
          else        void'(exp_q_m.pop_front());
        end
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      checkDut(0, vld_l, gnt_l, idx_l);
      checkDut(1, vld_m, gnt_m, idx_m);
    end
  end

  task automatic applyStimulus(input logic [W-1:0] r, input bit rdy, input bit rs, input int n);
    req     = r;
    gnt_rdy = rdy;
    rst     = rs;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req     = '0;
    gnt_rdy = 1'b0;
    rst     = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b1, 3);
    applyStimulus(4'b0000, 1'b0, 1'b0, 10);

    applyStimulus(4'b0000, 1'b0, 1'b1, 1);
    applyStimulus(4'b1010, 1'b1, 1'b0, 6);

    applyStimulus(4'b0000, 1'b0, 1'b1, 1);
    applyStimulus(4'b1111, 1'b1, 1'b0, 7);

    applyStimulus(4'b0000, 1'b0, 1'b1, 1);
    applyStimulus(4'b0110, 1'b0, 1'b0, 2);
    applyStimulus(4'b0100, 1'b0, 1'b0, 3);
    applyStimulus(4'b0100, 1'b1, 1'b0, 2);
    applyStimulus(4'b0000, 1'b1, 1'b0, 2);

    applyStimulus(4'b0000, 1'b0, 1'b1, 1);
    applyStimulus(4'b1000, 1'b0, 1'b0, 3);
    applyStimulus(4'b1000, 1'b1, 1'b1, 1);
    applyStimulus(4'b1001, 1'b0, 1'b0, 2);
    applyStimulus(4'b1001, 1'b1, 1'b0, 3);

    applyStimulus(4'b0000, 1'b0, 1'b1, 1);
    applyStimulus(4'b0001, 1'b0, 1'b0, 2);
    applyStimulus(4'b0000, 1'b1, 1'b0, 3);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(W'($urandom_range(0, 15)), ($urandom % 4) != 0,
                    ($urandom % 64) == 0, 1);
    end

    applyStimulus(4'b0000, 1'b1, 1'b0, 4);
    checkOutput("lsb_drain", 32'(exp_q_l.size()), 32'd0);
    checkOutput("msb_drain", 32'(exp_q_m.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
